seq_bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It is generalised in input width and digit count. A start/busy/done handshake lets a display or TDM scan path request conversions. It replaces the purely combinational divide/modulo converter, whose divider chain does not scale with wide inputs, and adds an overflow flag for values exceeding the digit capacity.

---
 rtl/seq_bin_to_bcd.sv | 107 ++++++++++
 tb/tb_seq_bin_to_bcd.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// with start/busy/done handshake and a sticky overflow for values beyond DIGITS.
module seq_bin_to_bcd #(
   parameter int unsigned BIN_W  = 10,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [BIN_W-1:0]   r_shift;
   logic [BCD_W-1:0]   r_work;
   logic               r_sticky;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_ovf;

   logic [BCD_W-1:0]   w_corr;
   logic [BCD_W-1:0]   w_work_nx;
   logic [BIN_W-1:0]   w_shift_nx;
   logic               w_carry;

   // Add-3 correction of every digit >= 5 ahead of the shift
   always_comb begin
      w_corr = r_work;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (r_work[4*k +: 4] >= 4'd5) begin
            w_corr[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
         end
      end
   end

   // The bit leaving the top digit is a 10^DIGITS carry, i.e. overflow
   assign {w_carry, w_work_nx, w_shift_nx} = {w_corr, r_shift, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_work   <= '0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_bcd    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_shift  <= bin;
                  r_work   <= '0;
                  r_sticky <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_SHIFT;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_shift  <= w_shift_nx;
               r_work   <= w_work_nx;
               r_sticky <= r_sticky | w_carry;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_bcd   <= w_work_nx;
                  r_ovf   <= r_sticky | w_carry;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: a 4-digit and a 3-digit instance checked against
// a decimal /10, %10 reference model.
module tb_seq_bin_to_bcd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start4 = 1'b0, start3 = 1'b0;
   logic [9:0]  bin4 = '0, bin3 = '0;
   logic        busy4, done4, ovf4, busy3, done3, ovf3;
   logic [15:0] bcd4;
   logic [11:0] bcd3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_bin_to_bcd #(.BIN_W(10), .DIGITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
      .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4));

   seq_bin_to_bcd #(.BIN_W(10), .DIGITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .bin(bin3),
      .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

   typedef struct {
      int          val;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
   } vec_t;

   function automatic logic [15:0] ref_bcd(input int v, input int nd);
      int x = v;
      logic [15:0] r = '0;
      for (int k = 0; k < nd; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int v, input int nd);
      int p = 1;
      for (int k = 0; k < nd; k++) p = p * 10;
      return (v > p - 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One conversion on the selected instance; cyc counts cycles from the one
   // in which start is presented up to and including the first done cycle.
   task automatic run(input int which, input int v, output logic [15:0] b,
                      output logic o, output int cyc, output int bcyc);
      logic d;
      @(negedge clk);
      if (which == 4) begin start4 = 1'b1; bin4 = 10'(v); end
      else begin start3 = 1'b1; bin3 = 10'(v); end
      @(negedge clk);
      start4 = 1'b0; start3 = 1'b0;
      bin4 = 10'($urandom); bin3 = 10'($urandom);
      cyc = 1; bcyc = 0;
      d = 1'b0;
      while (cyc < 40) begin
         d = (which == 4) ? done4 : done3;
         if (d) break;
         if ((which == 4) ? busy4 : busy3) bcyc++;
         @(negedge clk);
         cyc++;
      end
      if (!d) chk("done_timeout", 32'(cyc), 32'd11);
      b = (which == 4) ? bcd4 : {4'h0, bcd3};
      o = (which == 4) ? ovf4 : ovf3;
   endtask

   initial begin
      vec_t        vecs[10];
      logic [15:0] b;
      logic        o;
      int          cyc, bcyc, ndone, idx;
      int          tdone[2];
      logic [15:0] bdone[2];

      vecs[0] = '{0,    16'h0000, 1'b0};
      vecs[1] = '{1023, 16'h1023, 1'b0};
      vecs[2] = '{999,  16'h0999, 1'b0};
      vecs[3] = '{512,  16'h0512, 1'b0};
      vecs[4] = '{7,    16'h0007, 1'b0};
      vecs[5] = '{1,    16'h0001, 1'b0};
      vecs[6] = '{10,   16'h0010, 1'b0};
      vecs[7] = '{99,   16'h0099, 1'b0};
      vecs[8] = '{100,  16'h0100, 1'b0};
      vecs[9] = '{640,  16'h0640, 1'b0};

      #23;
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_done", 32'(done4), 32'd0);
      chk("rst_bcd", 32'(bcd4), 32'd0);
      chk("rst_ovf", 32'(ovf4), 32'd0);
      rst_n = 1'b1;

      // Latency and busy width on bin=0
      run(4, 0, b, o, cyc, bcyc);
      chk("lat_cycles", 32'(cyc), 32'd11);
      chk("lat_busy", 32'(bcyc), 32'd10);
      chk("lat_bcd", 32'(b), 32'h0000);
      @(negedge clk);
      chk("done_pulse", 32'(done4), 32'd0);

      for (int i = 0; i < 10; i++) begin
         run(4, vecs[i].val, b, o, cyc, bcyc);
         chk($sformatf("vec%0d_bcd", i), 32'(b), 32'(vecs[i].exp_bcd));
         chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
      end

      for (int v = 0; v < 1024; v++) begin
         run(4, v, b, o, cyc, bcyc);
         chk($sformatf("sweep%0d", v), {15'h0, o, b}, {15'h0, ref_ovf(v, 4), ref_bcd(v, 4)});
      end

      // Three-digit instance: overflow set then cleared
      run(3, 1000, b, o, cyc, bcyc);
      chk("d3_1000_bcd", 32'(b), 32'h000);
      chk("d3_1000_ovf", 32'(o), 32'd1);
      run(3, 57, b, o, cyc, bcyc);
      chk("d3_57_bcd", 32'(b), 32'h057);
      chk("d3_57_ovf", 32'(o), 32'd0);
      for (int i = 0; i < 150; i++) begin
         idx = int'($urandom_range(0, 1023));
         run(3, idx, b, o, cyc, bcyc);
         chk($sformatf("d3_rand%0d", idx), {15'h0, o, b}, {15'h0, ref_ovf(idx, 3), ref_bcd(idx, 3)});
      end

      // start re-pulsed mid-conversion is ignored
      @(negedge clk); start4 = 1'b1; bin4 = 10'd512;
      @(negedge clk); start4 = 1'b0;
      repeat (2) @(negedge clk);
      start4 = 1'b1; bin4 = 10'd7;
      @(negedge clk); start4 = 1'b0;
      ndone = 0; b = '0;
      for (int k = 0; k < 20; k++) begin
         if (done4) begin ndone++; b = bcd4; end
         @(negedge clk);
      end
      chk("ignore_ndone", 32'(ndone), 32'd1);
      chk("ignore_bcd", 32'(b), 32'h0512);

      // start held high: back-to-back conversions
      @(negedge clk); start4 = 1'b1; bin4 = 10'd999;
      @(negedge clk); bin4 = 10'd7;
      ndone = 0;
      for (int k = 1; k < 40 && ndone < 2; k++) begin
         if (done4) begin
            tdone[ndone] = k; bdone[ndone] = bcd4; ndone++;
            if (ndone == 2) start4 = 1'b0;
         end
         if (ndone < 2) @(negedge clk);
      end
      start4 = 1'b0;
      chk("b2b_ndone", 32'(ndone), 32'd2);
      if (ndone == 2) begin
         chk("b2b_gap", 32'(tdone[1] - tdone[0]), 32'd11);
         chk("b2b_first", 32'(bdone[0]), 32'h0999);
         chk("b2b_second", 32'(bdone[1]), 32'h0007);
      end
      repeat (3) @(negedge clk);
      chk("b2b_idle", 32'(busy4), 32'd0);

      // Reset mid-conversion aborts immediately
      @(negedge clk); start4 = 1'b1; bin4 = 10'd800;
      @(negedge clk); start4 = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", 32'(busy4), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_done", 32'(done4), 32'd0);
      chk("abort_bcd", 32'(bcd4), 32'd0);
      chk("abort_ovf", 32'(ovf4), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done4) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      run(4, 345, b, o, cyc, bcyc);
      chk("post_rst_bcd", 32'(b), 32'h0345);
      chk("post_rst_lat", 32'(cyc), 32'd11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
